// File: rtl/vecmac_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vecmac_pkg
// Description : Shared constants and the FSM state type for the int8
//               dot-product sequencer and its lane-reduction stage.
// Revision    : 1.0 - initial release
// ============================================================================
package vecmac_pkg;

  localparam int LANES      = 4;   // elements per operand beat
  localparam int LANE_W     = 8;   // unsigned element width
  localparam int PROD_W     = 16;  // per-lane product width
  localparam int BEAT_SUM_W = 18;  // sum of four 16-bit products

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } vecmac_state_t;

endpackage : vecmac_pkg
`default_nettype wire

// File: rtl/vecmac_lane_sum.sv
`default_nettype none
// ============================================================================
// Module      : vecmac_lane_sum
// Description : Combinational reduction of the four 16-bit lane products of
//               one multiplier beat into an 18-bit sum (two-level adder tree).
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   products  in  LANES*PROD_W  {p3,p2,p1,p0}, unsigned
//   sum       out BEAT_SUM_W    p0+p1+p2+p3
// ============================================================================
module vecmac_lane_sum
  import vecmac_pkg::*;
(
  input  logic [LANES*PROD_W-1:0] products,
  output logic [BEAT_SUM_W-1:0]   sum
);

  logic [PROD_W-1:0] w_lane [LANES];

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      assign w_lane[gi] = products[gi*PROD_W +: PROD_W];
    end
  endgenerate

  // First level keeps one carry bit, second level a second one.
  logic [PROD_W:0] w_pair_lo;
  logic [PROD_W:0] w_pair_hi;

  assign w_pair_lo = {1'b0, w_lane[0]} + {1'b0, w_lane[1]};
  assign w_pair_hi = {1'b0, w_lane[2]} + {1'b0, w_lane[3]};
  assign sum       = {1'b0, w_pair_lo} + {1'b0, w_pair_hi};

endmodule : vecmac_lane_sum
`default_nettype wire

// File: rtl/vecmac_dot_seq.sv
`default_nettype none
// ============================================================================
// Module      : vecmac_dot_seq
// Description : Sequencer for an unsigned int8 dot product of LEN beats
//               (4 elements each) on an external 4-lane 8x8 multiplier.
//               Operand beats are passed straight to the multiplier on the
//               handshake; returning products are reduced and accumulated,
//               and the sum is offered on a valid/ready result port.
// Revision    : 1.0 - initial release
// Build macro : VECMAC_SAT_EN - saturating accumulator with sticky ovf;
//               when undefined the accumulator wraps and ovf is 0.
// ----------------------------------------------------------------------------
// Parameters
//   LEN_W  beat-count width (max job = 2^LEN_W-1 beats)
//   ACC_W  accumulator / result width, must be >= 18
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   start, len               job request (sampled in IDLE only)
//   busy                     high outside IDLE
//   op_valid/op_ready        operand beat stream, op_a/op_b 4 x u8 each
//   mul_in_valid/a/b         issue port to the multiplier
//   mul_out_valid/product    multiplier result port, 4 x u16
//   res_valid/res_ready      result stream, res_data = sum, ovf = overflow
// ============================================================================
module vecmac_dot_seq
  import vecmac_pkg::*;
#(
  parameter int LEN_W = 8,
  parameter int ACC_W = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [LEN_W-1:0]          len,
  output logic                      busy,
  input  logic                      op_valid,
  output logic                      op_ready,
  input  logic [LANES*LANE_W-1:0]   op_a,
  input  logic [LANES*LANE_W-1:0]   op_b,
  output logic                      mul_in_valid,
  output logic [LANES*LANE_W-1:0]   mul_in_a,
  output logic [LANES*LANE_W-1:0]   mul_in_b,
  input  logic                      mul_out_valid,
  input  logic [LANES*PROD_W-1:0]   mul_product,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic [ACC_W-1:0]          res_data,
  output logic                      ovf
);

  vecmac_state_t    r_state;
  vecmac_state_t    w_state_next;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_issued;
  logic [LEN_W-1:0] r_received;
  logic [ACC_W-1:0] r_acc;
  logic [ACC_W-1:0] w_acc_next;
  logic [BEAT_SUM_W-1:0] w_beat_sum;

  logic w_job_start;
  logic w_handshake;
  logic w_accum;
  logic w_issue_last;
  logic w_recv_last;

  // --------------------------------------------------------------------------
  // Reduction of the returning beat
  // --------------------------------------------------------------------------
  vecmac_lane_sum u_lane_sum (
    .products (mul_product),
    .sum      (w_beat_sum)
  );

  // Operands are forwarded unconditionally; only the strobe is qualified.
  assign mul_in_a = op_a;
  assign mul_in_b = op_b;

  assign w_job_start  = (r_state == IDLE) && start;
  assign w_handshake  = op_valid && op_ready;
  assign w_accum      = mul_out_valid && ((r_state == RUN) || (r_state == DRAIN));
  assign w_issue_last = (r_issued + LEN_W'(1)) == r_len;
  assign w_recv_last  = w_accum && ((r_received + LEN_W'(1)) == r_len);

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state and control outputs
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    busy         = 1'b1;
    op_ready     = 1'b0;
    mul_in_valid = 1'b0;
    res_valid    = 1'b0;
    case (r_state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          w_state_next = (len == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        // Ready depends on counters only, never on op_valid.
        op_ready     = (r_issued < r_len);
        mul_in_valid = op_valid && op_ready;
        if (w_handshake && w_issue_last) begin
          w_state_next = DRAIN;
        end
      end
      DRAIN: begin
        // Leave on the cycle the final product is being accumulated.
        if (w_recv_last || (r_received == r_len)) begin
          w_state_next = DONE;
        end
      end
      DONE: begin
        res_valid = 1'b1;
        if (res_ready) begin
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Accumulator update (wrapping or saturating)
  // --------------------------------------------------------------------------
`ifdef VECMAC_SAT_EN
  logic [ACC_W:0] w_acc_sum;
  logic           r_ovf;

  assign w_acc_sum  = {1'b0, r_acc} + (ACC_W+1)'(w_beat_sum);
  assign w_acc_next = w_acc_sum[ACC_W] ? {ACC_W{1'b1}} : w_acc_sum[ACC_W-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (w_job_start) begin
      r_ovf <= 1'b0;
    end else if (w_accum && w_acc_sum[ACC_W]) begin
      r_ovf <= 1'b1;
    end
  end

  assign ovf = r_ovf;
`else
  assign w_acc_next = r_acc + ACC_W'(w_beat_sum);
  assign ovf        = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Counters and accumulator
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_len      <= '0;
      r_issued   <= '0;
      r_received <= '0;
      r_acc      <= '0;
    end else if (w_job_start) begin
      r_len      <= len;
      r_issued   <= '0;
      r_received <= '0;
      r_acc      <= '0;
    end else begin
      if (w_handshake) begin
        r_issued <= r_issued + LEN_W'(1);
      end
      if (w_accum) begin
        r_received <= r_received + LEN_W'(1);
        r_acc      <= w_acc_next;
      end
    end
  end

  // The accumulator is only cleared by start or reset, so the last result
  // stays visible after its handshake.
  assign res_data = r_acc;

endmodule : vecmac_dot_seq
`default_nettype wire

// File: tb/tb_vecmac_dot_seq.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_vecmac_dot_seq
// Description : Self-checking bench for vecmac_dot_seq. A 32-bit accumulator
//               instance runs directed and random jobs against a dot-product
//               reference; an 18-bit instance exercises accumulator overflow.
//               Both are served by a 1-cycle lane-multiplier model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vecmac_dot_seq;

  localparam int LEN_W = 8;
  localparam int ACC_W = 32;
  localparam int ACC_S = 18;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Main instance
  logic             start;
  logic [LEN_W-1:0] len;
  logic             busy;
  logic             op_valid;
  logic             op_ready;
  logic [31:0]      op_a;
  logic [31:0]      op_b;
  logic             mul_in_valid;
  logic [31:0]      mul_in_a;
  logic [31:0]      mul_in_b;
  logic             mul_out_valid;
  logic [63:0]      mul_product;
  logic             res_valid;
  logic             res_ready;
  logic [ACC_W-1:0] res_data;
  logic             ovf;

  // Narrow-accumulator instance
  logic             s_start;
  logic [LEN_W-1:0] s_len;
  logic             s_busy;
  logic             s_op_valid;
  logic             s_op_ready;
  logic [31:0]      s_op_a;
  logic [31:0]      s_op_b;
  logic             s_mul_in_valid;
  logic [31:0]      s_mul_in_a;
  logic [31:0]      s_mul_in_b;
  logic             s_mul_out_valid;
  logic [63:0]      s_mul_product;
  logic             s_res_valid;
  logic             s_res_ready;
  logic [ACC_S-1:0] s_res_data;
  logic             s_ovf;

  vecmac_dot_seq #(.LEN_W(LEN_W), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .busy(busy),
    .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
    .mul_in_valid(mul_in_valid), .mul_in_a(mul_in_a), .mul_in_b(mul_in_b),
    .mul_out_valid(mul_out_valid), .mul_product(mul_product),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .ovf(ovf)
  );

  vecmac_dot_seq #(.LEN_W(LEN_W), .ACC_W(ACC_S)) dut_s (
    .clk(clk), .rst(rst), .start(s_start), .len(s_len), .busy(s_busy),
    .op_valid(s_op_valid), .op_ready(s_op_ready), .op_a(s_op_a), .op_b(s_op_b),
    .mul_in_valid(s_mul_in_valid), .mul_in_a(s_mul_in_a), .mul_in_b(s_mul_in_b),
    .mul_out_valid(s_mul_out_valid), .mul_product(s_mul_product),
    .res_valid(s_res_valid), .res_ready(s_res_ready), .res_data(s_res_data), .ovf(s_ovf)
  );

  // 4-lane 8x8 multiplier, one cycle of latency.
  function automatic logic [63:0] mul4(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    for (int l = 0; l < 4; l++) p[16*l +: 16] = 16'(a[8*l +: 8]) * 16'(b[8*l +: 8]);
    return p;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mul_out_valid   <= 1'b0;
      mul_product     <= '0;
      s_mul_out_valid <= 1'b0;
      s_mul_product   <= '0;
    end else begin
      mul_out_valid   <= mul_in_valid;
      mul_product     <= mul4(mul_in_a, mul_in_b);
      s_mul_out_valid <= s_mul_in_valid;
      s_mul_product   <= mul4(s_mul_in_a, s_mul_in_b);
    end
  end

  int n_cmp  = 0;
  int n_fail = 0;

  logic [31:0] beat_a [0:16];
  logic [31:0] beat_b [0:16];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain sum of elementwise byte products over n beats.
  function automatic longint dot_ref(input int n);
    longint s = 0;
    for (int k = 0; k < n; k++)
      for (int l = 0; l < 4; l++)
        s += longint'(beat_a[k][8*l +: 8]) * longint'(beat_b[k][8*l +: 8]);
    return s;
  endfunction

  // pct < 0 selects a strict 1,0,1,0 op_valid pattern.
  task automatic run_job(input string tag, input int n, input int pct, input int hold);
    int cyc, idx, pulses, rdy, last_hs, bad_pass;
    logic [ACC_W-1:0] exp;
    exp = ACC_W'(dot_ref(n));
    start = 1'b1;
    len   = LEN_W'(n);
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0; idx = 0; pulses = 0; rdy = 0; last_hs = 0; bad_pass = 0;
    while (res_valid !== 1'b1 && cyc < 300) begin
      if (pct < 0) op_valid = (idx < n) && (cyc % 2 == 0);
      else         op_valid = (idx < n) && ($urandom_range(99) < pct);
      op_a = beat_a[idx];
      op_b = beat_b[idx];
      #1;
      if (op_ready === 1'b1) rdy++;
      if (mul_in_valid === 1'b1) begin
        pulses++;
        if (mul_in_a !== beat_a[idx] || mul_in_b !== beat_b[idx]) bad_pass++;
      end
      if (op_valid && op_ready === 1'b1) begin
        idx++;
        last_hs = cyc;
      end
      @(posedge clk); #1;
      cyc++;
    end
    op_valid = 1'b0;
    check({tag, " timeout"}, 64'(cyc < 300), 64'd1);
    check({tag, " issue_pulses"}, 64'(pulses), 64'(n));
    check({tag, " passthrough"}, 64'(bad_pass), 64'd0);
    check({tag, " res_data"}, 64'(res_data), 64'(exp));
    check({tag, " ovf"}, 64'(ovf), 64'd0);
    if (n > 0) check({tag, " latency"}, 64'(cyc - last_hs), 64'd2);
    else       check({tag, " done_next"}, 64'(cyc), 64'd0);
    if (pct == 100) check({tag, " ready_cycles"}, 64'(rdy), 64'(n));
    // Hold the result back; start/len must be ignored meanwhile.
    res_ready = 1'b0;
    for (int h = 0; h < hold; h++) begin
      start = 1'b1;
      len   = 8'd3;
      @(posedge clk); #1;
      check({tag, " hold"}, {31'd0, res_valid, 32'(res_data)}, {31'd0, 1'b1, 32'(exp)});
    end
    res_ready = 1'b1;
    start     = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    start     = 1'b0;
    check({tag, " to_idle"}, {62'd0, busy, res_valid}, 64'd0);
    check({tag, " res_kept"}, 64'(res_data), 64'(exp));
  endtask

  initial begin
    longint s_sum;
    logic [ACC_S-1:0] s_exp;
    logic s_exp_ovf;
    int cyc, hs;

    rst = 1'b1;
    start = 1'b0; len = '0; op_valid = 1'b0; op_a = '0; op_b = '0; res_ready = 1'b0;
    s_start = 1'b0; s_len = '0; s_op_valid = 1'b0; s_op_a = '0; s_op_b = '0; s_res_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", {58'd0, busy, op_ready, mul_in_valid, res_valid, ovf, |res_data}, 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Single beat: 1+2+3+4 = 10
    beat_a[0] = 32'h04030201; beat_b[0] = 32'h01010101;
    run_job("len1", 1, 100, 0);

    // Three all-FF beats, op_valid continuously high
    for (int k = 0; k < 3; k++) begin beat_a[k] = '1; beat_b[k] = '1; end
    run_job("len3_ff", 3, 100, 1);

    // Four beats, alternating op_valid, result held back for 5 cycles
    for (int k = 0; k < 4; k++) begin beat_a[k] = $urandom; beat_b[k] = $urandom; end
    run_job("len4_alt", 4, -1, 5);

    // Zero-length job
    run_job("len0", 0, 100, 0);

    // Reset in the middle of a 5-beat job
    for (int k = 0; k < 5; k++) begin beat_a[k] = $urandom; beat_b[k] = $urandom; end
    start = 1'b1; len = 8'd5;
    @(posedge clk); #1;
    start = 1'b0;
    hs = 0; cyc = 0;
    while (hs < 2 && cyc < 20) begin
      op_valid = 1'b1; op_a = beat_a[hs]; op_b = beat_b[hs];
      #1;
      if (op_ready === 1'b1) hs++;
      @(posedge clk); #1;
      cyc++;
    end
    check("rst_mid_reach", 64'(hs), 64'd2);
    rst = 1'b1;
    #1;
    check("rst_mid_outputs", {58'd0, busy, op_ready, mul_in_valid, res_valid, ovf, |res_data}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    op_valid = 1'b0;
    @(posedge clk); #1;
    for (int k = 0; k < 2; k++) begin beat_a[k] = 32'h01010101; beat_b[k] = 32'h01010101; end
    run_job("after_rst", 2, 100, 0);

    // Narrow accumulator: 8 all-FF beats overflow 18 bits
    s_sum = 0;
    for (int k = 0; k < 8; k++) s_sum += 4 * 255 * 255;
`ifdef VECMAC_SAT_EN
    s_exp_ovf = (s_sum > longint'((1 << ACC_S) - 1));
    s_exp     = s_exp_ovf ? {ACC_S{1'b1}} : s_sum[ACC_S-1:0];
`else
    s_exp_ovf = 1'b0;
    s_exp     = s_sum[ACC_S-1:0];
`endif
    s_start = 1'b1; s_len = 8'd8; s_op_valid = 1'b1; s_op_a = '1; s_op_b = '1;
    @(posedge clk); #1;
    s_start = 1'b0;
    cyc = 0;
    while (s_res_valid !== 1'b1 && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    s_op_valid = 1'b0;
    check("acc18 timeout", 64'(cyc < 40), 64'd1);
    check("acc18 res_data", 64'(s_res_data), 64'(s_exp));
    check("acc18 ovf", 64'(s_ovf), 64'(s_exp_ovf));
    s_res_ready = 1'b1;
    @(posedge clk); #1;
    s_res_ready = 1'b0;
    check("acc18 to_idle", {62'd0, s_busy, s_res_valid}, 64'd0);

    // Random jobs with random bubbles and hold times
    for (int j = 0; j < 6; j++) begin
      int n;
      n = $urandom_range(12, 1);
      for (int k = 0; k < n; k++) begin beat_a[k] = $urandom; beat_b[k] = $urandom; end
      run_job($sformatf("rand%0d", j), n, $urandom_range(100, 40), $urandom_range(3, 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule : tb_vecmac_dot_seq
`default_nettype wire
